// File: rtl/seq_pkg.sv
// seq_pkg: FSM state encoding and default parameters shared by the sample_sequencer slice.
package seq_pkg;
    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} seq_state_e;
    localparam int ADDR_W_DEF        = 4;
    localparam int DEPTH_DEF         = 16;
    localparam int SAMPLE_CYCLES_DEF = 8;
    localparam int BRAM_LAT_DEF      = 1;
    localparam int PIPE_LAT_DEF      = 4;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that stops at zero; zero_o flags the last cycle of an interval.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         CLK100MHZ,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge CLK100MHZ) cnt_q <= reset ? '0 : cnt_d;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: steps BRAM samples out to the encoder at a fixed cadence, then flushes the pipeline.
// Define SEQ_LOOP_EN to add the loop_mode input for endless wrap-around playback.
module sample_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DEPTH         = DEPTH_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int BRAM_LAT      = BRAM_LAT_DEF,
    parameter int PIPE_LAT      = PIPE_LAT_DEF
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
`ifdef SEQ_LOOP_EN
    input  logic              loop_mode,
`endif
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              sample_load,
    output logic [ADDR_W-1:0] sample_idx,
    output logic              pipe_en,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMR_W = $clog2(max3(SAMPLE_CYCLES, BRAM_LAT, PIPE_LAT) + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH);

    seq_state_e state_q, state_d;
    logic start_q, start_prev_q, start_arm_q, rise, loop_en;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, idx_q, idx_d;
    logic load_q, load_d;
    logic tmr_load, tmr_zero;
    logic [TMR_W-1:0] tmr_val;

`ifdef SEQ_LOOP_EN
    assign loop_en = loop_mode;
`else
    assign loop_en = 1'b0;
`endif

    // arm only after start has been seen low, so a level held through reset cannot launch a run
    assign rise = start_q & ~start_prev_q & start_arm_q;

    seq_timer #(.W(TMR_W)) u_timer (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state_q      <= IDLE;
            start_q      <= 1'b0;
            start_prev_q <= 1'b0;
            start_arm_q  <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            idx_q        <= '0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_q      <= start;
            start_prev_q <= start_q;
            start_arm_q  <= start_arm_q | ~start;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            idx_q        <= idx_d;
            load_q       <= load_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        load_d   = 1'b0;
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (rise && !abort) begin
                    state_d  = PRIME;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(BRAM_LAT - 1);
                end
                PRIME: if (tmr_zero) begin
                    state_d  = RUN;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(SAMPLE_CYCLES - 1);
                    load_d   = 1'b1;
                end
                RUN: if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if (cnt_q == LAST && !loop_en) begin
                        state_d = DRAIN;
                        tmr_val = TMR_W'(PIPE_LAT - 1);
                    end else begin
                        tmr_val = TMR_W'(SAMPLE_CYCLES - 1);
                        load_d  = 1'b1;
                    end
                end
                DRAIN: if (tmr_zero) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // in loop mode the sample after the DEPTH-th restarts at address 0 and count 1
    always_comb begin
        cnt_d  = (state_d == IDLE) ? '0 : !load_d ? cnt_q : (cnt_q == LAST) ? CNT_W'(1) : cnt_q + 1'b1;
        addr_d = (state_d == IDLE) ? '0 : !load_d ? addr_q : (loop_en && cnt_q == LAST - 1'b1) ? '0 : addr_q + 1'b1;
        idx_d  = (state_d == IDLE) ? '0 : load_d ? addr_q : idx_q;
        bram_en     = state_q == PRIME || (state_q == RUN && (loop_en || cnt_q != LAST || load_q));
        bram_addr   = addr_q;
        sample_load = load_q;
        sample_idx  = idx_q;
        pipe_en     = state_q == RUN || state_q == DRAIN;
        busy        = state_q != IDLE;
        done        = state_q == DONE;
    end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: scoreboard bench for sample_sequencer; define SEQ_LOOP_EN to cover loop_mode.
module tb_sample_sequencer;
    logic CLK100MHZ = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
`ifdef SEQ_LOOP_EN
    logic loop_mode = 1'b0;
`endif
    logic bram_en, sample_load, pipe_en, busy, done;
    logic [3:0] bram_addr, sample_idx;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int t0;

    typedef struct {
        bit is_done;
        int cycle;
        int idx;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    always #5 CLK100MHZ = ~CLK100MHZ;
    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    sample_sequencer dut (
        .CLK100MHZ   (CLK100MHZ),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
`ifdef SEQ_LOOP_EN
        .loop_mode   (loop_mode),
`endif
        .bram_en     (bram_en),
        .bram_addr   (bram_addr),
        .sample_load (sample_load),
        .sample_idx  (sample_idx),
        .pipe_en     (pipe_en),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge CLK100MHZ);
            #1;
        end
    endtask

    task automatic push_run(input int ts, input int n, input bit with_done);
        for (int k = 0; k < n; k++) exp_q.push_back('{1'b0, ts + 2 + 8 * k, k % 16});
        if (with_done) exp_q.push_back('{1'b1, ts + 134, 0});
    endtask

    task automatic purge(input int after);
        while (exp_q.size() > 0 && exp_q[$].cycle > after) void'(exp_q.pop_back());
    endtask

    task automatic launch(input int n, input bit with_done);
        start = 1'b1;
        t0 = cyc + 1;
        push_run(t0, n, with_done);
    endtask

    always @(negedge CLK100MHZ) begin
        if (sample_load === 1'b1 || done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: load=%0b done=%0b at cycle %0d, none required", sample_load, done, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", int'(done), int'(mon_e.is_done));
                check("event_cycle", cyc, mon_e.cycle);
                if (!mon_e.is_done) begin
                    check("load_idx", int'(sample_idx), mon_e.idx);
                    check("load_addr", int'(bram_addr), (mon_e.idx + 1) % 16);
                end
            end
        end
    end

    initial begin
        at(2);
        check("rst_busy", int'(busy), 0);
        check("rst_bram_en", int'(bram_en), 0);
        check("rst_addr", int'(bram_addr), 0);
        check("rst_load", int'(sample_load), 0);
        check("rst_idx", int'(sample_idx), 0);
        check("rst_pipe_en", int'(pipe_en), 0);
        check("rst_done", int'(done), 0);
        at(3);
        reset = 1'b0;

        at(5);
        launch(16, 1'b1);
        at(t0 + 1);
        check("prime_busy", int'(busy), 1);
        check("prime_bram_en", int'(bram_en), 1);
        check("prime_pipe_en", int'(pipe_en), 0);
        at(t0 + 5);
        start = 1'b0;
        at(t0 + 122);
        check("bram_en_last_load", int'(bram_en), 1);
        at(t0 + 123);
        check("bram_en_after_last", int'(bram_en), 0);
        at(t0 + 133);
        check("drain_pipe_en", int'(pipe_en), 1);
        at(t0 + 134);
        check("done_pipe_en", int'(pipe_en), 0);
        check("done_busy", int'(busy), 1);
        at(t0 + 135);
        check("idle_busy", int'(busy), 0);
        check("idle_addr", int'(bram_addr), 0);
        check("run1_pending", exp_q.size(), 0);

        at(t0 + 140);
        launch(16, 1'b1);
        at(t0 + 5);
        start = 1'b0;
        at(t0 + 49);
        start = 1'b1;
        at(t0 + 55);
        start = 1'b0;
        at(t0 + 136);
        check("repulse_busy", int'(busy), 0);
        check("repulse_pending", exp_q.size(), 0);

        at(t0 + 140);
        launch(16, 1'b1);
        at(t0 + 5);
        start = 1'b0;
        at(t0 + 60);
        abort = 1'b1;
        purge(t0 + 60);
        at(t0 + 61);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_pipe_en", int'(pipe_en), 0);
        check("abort_bram_en", int'(bram_en), 0);
        at(t0 + 200);
        check("abort_pending", exp_q.size(), 0);
        launch(16, 1'b1);
        at(t0 + 5);
        start = 1'b0;
        at(t0 + 136);
        check("post_abort_pending", exp_q.size(), 0);

        at(t0 + 140);
        start = 1'b1;
        at(cyc + 1);
        abort = 1'b1;
        at(cyc + 1);
        abort = 1'b0;
        at(cyc + 2);
        check("abort_vs_start_busy", int'(busy), 0);
        at(cyc + 5);
        start = 1'b0;
        check("abort_vs_start_later", int'(busy), 0);

        at(cyc + 5);
        launch(16, 1'b1);
        at(t0 + 70);
        reset = 1'b1;
        purge(t0 + 70);
        at(t0 + 71);
        check("midrst_busy", int'(busy), 0);
        check("midrst_bram_en", int'(bram_en), 0);
        check("midrst_pipe_en", int'(pipe_en), 0);
        check("midrst_addr", int'(bram_addr), 0);
        check("midrst_idx", int'(sample_idx), 0);
        at(t0 + 73);
        reset = 1'b0;
        at(t0 + 100);
        check("held_start_no_run", int'(busy), 0);
        start = 1'b0;
        at(t0 + 103);
        launch(16, 1'b1);
        at(t0 + 5);
        start = 1'b0;
        at(t0 + 136);
        check("post_rst_pending", exp_q.size(), 0);
        check("post_rst_busy", int'(busy), 0);

`ifdef SEQ_LOOP_EN
        at(t0 + 140);
        loop_mode = 1'b1;
        launch(38, 1'b0);
        at(t0 + 5);
        start = 1'b0;
        at(t0 + 123);
        check("loop_bram_en", int'(bram_en), 1);
        at(t0 + 300);
        check("loop_still_busy", int'(busy), 1);
        abort = 1'b1;
        purge(t0 + 300);
        at(t0 + 301);
        abort = 1'b0;
        loop_mode = 1'b0;
        check("loop_abort_busy", int'(busy), 0);
        check("loop_pending", exp_q.size(), 0);
`endif

        at(cyc + 5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sample_sequencer.md
SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 Parameter ADDR_W, 4: BRAM address width.
REQ-002 Parameter DEPTH, 16: samples per run, 1..2**ADDR_W.
REQ-003 Parameter SAMPLE_CYCLES, 8: clocks each sample is held for the serial encoder; SHALL be at least BRAM_LAT+1.
REQ-004 Parameter BRAM_LAT, 1: BRAM read latency in clocks, 1..3.
REQ-005 Parameter PIPE_LAT, 4: decode+filter flush clocks after the last sample.
REQ-006 Clock and reset SHALL be: reset reset, synchronous, active-high; clock CLK100MHZ.
REQ-007 CLK100MHZ  in  1  system clock.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 start  in  1  run request, level input; acted on at its rising edge only.
REQ-010 abort  in  1  synchronous stop request.
REQ-011 bram_en  out  1  BRAM read enable.
REQ-012 bram_addr  out  ADDR_W  BRAM read address.
REQ-013 sample_load  out  1  one-cycle pulse; BRAM data is valid for the encoder this cycle.
REQ-014 sample_idx  out  ADDR_W  index of the most recently loaded sample.
REQ-015 pipe_en  out  1  enable level for encode, decode and filter.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when a run completes.

Function
REQ-018 FSM states SHALL be IDLE, PRIME, RUN, DRAIN and DONE.
REQ-019 IDLE: outputs low, bram_addr=0; on a registered start rising edge, go to PRIME with bram_en=1 and bram_addr=0.
REQ-020 PRIME: hold for BRAM_LAT cycles, then go to RUN.
REQ-021 First sample_load SHALL occur exactly BRAM_LAT+1 cycles after the edge that registers the start rise.
REQ-022 Later sample_loads SHALL be spaced exactly SAMPLE_CYCLES cycles apart.
REQ-023 On each sample_load, sample_idx takes the current bram_addr, and bram_addr increments modulo 2**ADDR_W.
REQ-024 pipe_en SHALL be high from the first sample_load until DRAIN exits.
REQ-025 After the DEPTH-th sample_load, bram_en deasserts on the next cycle.
REQ-026 SAMPLE_CYCLES cycles after the DEPTH-th sample_load, enter DRAIN for PIPE_LAT cycles.
REQ-027 After DRAIN, enter DONE: done pulses 1 cycle, then return to IDLE.
REQ-028 A start rising edge while busy SHALL be ignored; no queuing.
REQ-029 abort high in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse.
REQ-030 abort SHALL take priority over a simultaneous start edge.
REQ-031 Counters SHALL be sized from their parameters with no overflow; sample counter width is clog2(DEPTH+1).

Reset
REQ-032 reset SHALL force IDLE and clear all outputs, counters and the start edge register, mid-run included.
REQ-033 A start held high through reset deassertion SHALL NOT trigger a run.

Configuration
REQ-034 Macro SEQ_LOOP_EN, when defined: add input loop_mode (1 bit); with loop_mode=1 the DEPTH-th load is followed by address wrap to 0 and continued RUN, with no DRAIN or done, until abort or reset.
REQ-035 Without SEQ_LOOP_EN: no loop_mode port exists, and every run terminates per REQ-026/027.

Structure
REQ-036 Package seq_pkg SHALL hold the FSM state enum and the parameter defaults.
REQ-037 One sub-module, seq_timer, SHALL provide a loadable down-counter used for PRIME, per-sample and DRAIN timing.

Verification (defaults)
REQ-038 Normal run: start rise -> first sample_load at +2, 16 loads at +2, +10, ..., +122, done at +134, busy falls after done.
REQ-039 Address trace: bram_addr sequence 0..15, sample_idx equals load order, and bram_en=0 from +123.
REQ-040 Start re-pulsed at +50 -> no effect; done still at +134.
REQ-041 abort at +60 -> IDLE at +61, pipe_en=0, no done; a fresh start then yields done 134 cycles later.
REQ-042 reset asserted at +70 with start held high -> all outputs 0, no run until start falls then rises.
REQ-043 SEQ_LOOP_EN with loop_mode=1 -> load 17 at +130 with sample_idx=0, and no done within 300 cycles.
